// File: rtl/uart_auth_rx.sv
// rtl/uart_auth_rx.sv - UART command receiver and power-up authorization FSM; define RX_PARITY_EN for 8E1 framing
module uart_auth_rx #(
  parameter int          BAUD_DIV = 2604,
  parameter logic [7:0]  CMD_GO   = 8'h47,
  parameter logic [7:0]  CMD_STOP = 8'h53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       pwr_up
);

  localparam int          CW   = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
`ifdef RX_PARITY_EN
  localparam logic [2:0] RX_PAR   = 3'd4;
`endif

  localparam logic [1:0] AUTH_OFF  = 2'd0;
  localparam logic [1:0] AUTH_PWR1 = 2'd1;
  localparam logic [1:0] AUTH_PWR2 = 2'd2;

  logic          rx_ff1, rx_ff2, rx_ff3;
  logic [1:0]    warm;
  logic          seen_high;
  logic          start_edge;
  logic [2:0]    rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_ok;
  logic [1:0]    auth_state, auth_next;

  // Presets look like an idle line, so the edge detector is only armed once
  // the synchronizer carries real samples and the line has actually been high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1    <= 1'b1;
      rx_ff2    <= 1'b1;
      rx_ff3    <= 1'b1;
      warm      <= 2'd0;
      seen_high <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
      rx_ff3 <= rx_ff2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm == 2'd3 && rx_ff2) seen_high <= 1'b1;
    end
  end

  assign start_edge = seen_high & rx_ff3 & ~rx_ff2;

`ifdef RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bit <= 1'b0;
    else if (rx_state == RX_PAR && baud_cnt == ONE) par_bit <= rx_ff2;
  end
  assign par_ok = ((^shift) == par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (start_edge) begin
          baud_cnt <= HALF;
          rx_state <= RX_START;
        end
      end else if (baud_cnt != ONE) begin
        baud_cnt <= baud_cnt - ONE;
      end else begin
        baud_cnt <= FULL;
        case (rx_state)
          RX_START: begin
            if (rx_ff2) begin
              rx_state <= RX_IDLE;
            end else begin
              bit_cnt  <= 3'd0;
              rx_state <= RX_DATA;
            end
          end
          RX_DATA: begin
            shift   <= {rx_ff2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
`ifdef RX_PARITY_EN
            if (bit_cnt == 3'd7) rx_state <= RX_PAR;
`else
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
`endif
          end
`ifdef RX_PARITY_EN
          RX_PAR: rx_state <= RX_STOP;
`endif
          RX_STOP: begin
            if (rx_ff2 && par_ok) begin
              rx_data <= shift;
              rx_rdy  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // In PWR2 a fresh GO outranks a simultaneous rider departure.
  always_comb begin
    auth_next = auth_state;
    case (auth_state)
      AUTH_OFF:
        if (rx_rdy && rx_data == CMD_GO) auth_next = AUTH_PWR1;
      AUTH_PWR1:
        if (rx_rdy && rx_data == CMD_STOP) auth_next = rider_off ? AUTH_OFF : AUTH_PWR2;
      AUTH_PWR2:
        if (rx_rdy && rx_data == CMD_GO) auth_next = AUTH_PWR1;
        else if (rider_off)              auth_next = AUTH_OFF;
      default: auth_next = AUTH_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_state <= AUTH_OFF;
      pwr_up     <= 1'b0;
    end else begin
      auth_state <= auth_next;
      pwr_up     <= (auth_next != AUTH_OFF);
    end
  end

endmodule

// File: tb/tb_uart_auth_rx.sv
// tb/tb_uart_auth_rx.sv - directed and randomized bench for uart_auth_rx
module tb_uart_auth_rx;

  localparam int B = 64;
  localparam int H = B / 2;
`ifdef RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Pin edge to rx_rdy seen on the following falling edge: sync + half bit + remaining bits.
  localparam int LAT = 4 + H + (NBITS - 1) * B;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       pwr_up;

  int errors = 0;
  int checks = 0;

  uart_auth_rx #(.BAUD_DIV(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err),
    .pwr_up    (pwr_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0, rdy_cnt = 0, err_cnt = 0, both_cnt = 0, rdy_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       pwr_at_rdy = 1'b0, pwr_after_rdy = 1'b0, rdy_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rdy_d) pwr_after_rdy = pwr_up;
    rdy_d = rx_rdy;
    if (rx_rdy) begin
      rdy_cnt++;
      last_data  = rx_data;
      rdy_cyc    = cyc;
      pwr_at_rdy = pwr_up;
    end
    if (frame_err) err_cnt++;
    if (rx_rdy && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int start_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    logic [11:0] bits;
    bits = 12'hfff;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef RX_PARITY_EN
    bits[9]  = ^b;
    bits[10] = stop_bit;
`else
    bits[9]  = stop_bit;
`endif
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < NBITS; i++) begin
      RX = bits[i];
      if (i == rst_bit) begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_frame_reset_outputs", {20'h0, rx_data, rx_rdy, frame_err, pwr_up}, 32'h0);
        rst_n = 1'b1;
        repeat (B - 3) @(posedge clk);
        #1;
      end else begin
        repeat (B) @(posedge clk);
        #1;
      end
    end
    RX = 1'b1;
    repeat (2 * B) @(posedge clk);
    #1;
  endtask

  int         r0, e0, lat, mode, pick;
  logic [7:0] b;
  logic       r;

  initial begin
    rst_n = 1'b0; RX = 1'b1; rider_off = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", {20'h0, rx_data, rx_rdy, frame_err, pwr_up}, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_idle", {20'h0, rx_data, rx_rdy, frame_err, pwr_up}, 32'h0);

    // GO from OFF powers up one cycle after rx_rdy
    r0 = rdy_cnt;
    send_byte(8'h47, 1'b1, -1);
    chk("go_rdy_count", rdy_cnt - r0, 1);
    chk("go_data", last_data, 8'h47);
    lat = rdy_cyc - start_cyc;
    chk($sformatf("go_latency_%0d", lat), (lat >= LAT - 2 && lat <= LAT + 2), 1);
    chk("go_pwr_at_rdy", pwr_at_rdy, 0);
    chk("go_pwr_after_rdy", pwr_after_rdy, 1);

    // STOP with rider on holds power, then departure drops it
    send_byte(8'h53, 1'b1, -1);
    chk("stop_rider_on_pwr", pwr_up, 1);
    rider_off = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rider_leaves_pwr", pwr_up, 0);

    // STOP with rider already off drops power immediately
    send_byte(8'h47, 1'b1, -1);
    chk("go_again_pwr", pwr_up, 1);
    send_byte(8'h53, 1'b1, -1);
    chk("stop_rider_off_at_rdy", pwr_at_rdy, 1);
    chk("stop_rider_off_after", pwr_after_rdy, 0);

    // Unrecognised byte then STOP while OFF
    rider_off = 1'b0;
    r0 = rdy_cnt;
    send_byte(8'h41, 1'b1, -1);
    chk("off_0x41_data", last_data, 8'h41);
    chk("off_0x41_pwr", pwr_up, 0);
    send_byte(8'h53, 1'b1, -1);
    chk("off_0x53_data", last_data, 8'h53);
    chk("off_two_pulses", rdy_cnt - r0, 2);
    chk("off_0x53_pwr", pwr_up, 0);

    // Bad stop bit
    r0 = rdy_cnt; e0 = err_cnt;
    send_byte(8'h47, 1'b0, -1);
    chk("ferr_pulse", err_cnt - e0, 1);
    chk("ferr_no_rdy", rdy_cnt - r0, 0);
    chk("ferr_data_held", rx_data, 8'h53);
    chk("ferr_pwr", pwr_up, 0);
    send_byte(8'h47, 1'b1, -1);
    chk("after_ferr_go_pwr", pwr_up, 1);

    // Short low glitch on the line
    r0 = rdy_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (H - 12) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (3 * B) @(posedge clk);
    #1;
    chk("glitch_no_rdy", rdy_cnt - r0, 0);
    chk("glitch_no_err", err_cnt - e0, 0);
    chk("glitch_pwr_kept", pwr_up, 1);

    // Reset during data bit 3 of an all-zero byte, then a clean frame
    r0 = rdy_cnt; e0 = err_cnt;
    send_byte(8'h00, 1'b1, 4);
    chk("rst_frame_no_rdy", rdy_cnt - r0, 0);
    chk("rst_frame_no_err", err_cnt - e0, 0);
    send_byte(8'h47, 1'b1, -1);
    chk("after_rst_data", rx_data, 8'h47);
    chk("after_rst_pwr", pwr_up, 1);

    // Random command stream against a rule-level model.
    // mode: 0 unpowered, 1 powered, 2 powered but waiting for the rider to step off.
    mode = 1;
    for (int k = 0; k < 16; k++) begin
      pick = $urandom_range(0, 3);
      b = (pick == 0) ? 8'h47 : (pick == 1) ? 8'h53 : 8'($urandom_range(0, 255));
      r = 1'($urandom_range(0, 1));
      rider_off = r;
      if (mode == 2 && r) mode = 0;
      if (b == 8'h47) mode = 1;
      else if (b == 8'h53 && mode == 1) mode = r ? 0 : 2;
      r0 = rdy_cnt;
      send_byte(b, 1'b1, -1);
      chk($sformatf("rand%0d_rdy", k), rdy_cnt - r0, 1);
      chk($sformatf("rand%0d_data", k), rx_data, b);
      chk($sformatf("rand%0d_pwr", k), pwr_up, (mode != 0));
    end

    chk("rdy_ferr_never_together", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
